// File: rtl/upct_plru.sv
// Upper-PC table: small fully associative store of upper target-PC fields.
// BTB entries keep only an index into this table. Lookups either hit an
// existing entry or allocate one: the lowest invalid entry first, else the
// tree-PLRU victim. A read port returns a stored field and also refreshes
// that entry's recency. Flush invalidates everything and clears the tree.
module upct_plru #(
  parameter int UPCT_ENTRIES     = 8,
  parameter int LOG_UPCT_ENTRIES = $clog2(UPCT_ENTRIES),
  parameter int UPPER_PC_WIDTH   = 21
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        read_valid_in,
  input  logic [LOG_UPCT_ENTRIES-1:0] read_index_in,
  output logic [UPPER_PC_WIDTH-1:0]   read_upper_PC_out,
  input  logic                        update_valid_in,
  input  logic [UPPER_PC_WIDTH-1:0]   update_upper_PC_in,
  output logic                        update_ack_out,
  output logic                        update_hit_out,
  output logic [LOG_UPCT_ENTRIES-1:0] update_index_out,
  input  logic                        flush_in
);

  localparam int N     = UPCT_ENTRIES;
  localparam int L     = LOG_UPCT_ENTRIES;
  localparam int NODES = UPCT_ENTRIES - 1;

  // Storage. The array carries no reset; its contents are meaningless until
  // the matching valid bit is set.
  logic [UPPER_PC_WIDTH-1:0] array_reg [N];
  logic [N-1:0]              valid_reg;
  logic [N-1:0]              valid_next;
  // Heap-ordered PLRU tree: node n has children 2n+1 and 2n+2.
  // A node bit of 0 means the victim lies in the lower-index half.
  logic [NODES-1:0]          plru_reg;
  logic [NODES-1:0]          plru_next;
  logic [NODES-1:0]          plru_after_read;

  logic [N-1:0]              match_vec;
  logic [N-1:0]              victim_onehot;
  logic [L-1:0]              leaf_agree [N];

  logic                      upd_hit;
  logic                      any_free;
  logic                      upd_accept;
  logic                      upd_write;
  logic [L-1:0]              hit_idx;
  logic [L-1:0]              free_idx;
  logic [L-1:0]              victim_idx;
  logic [L-1:0]              target_idx;

  // Associative compare against every valid entry.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_match
      assign match_vec[gi] = valid_reg[gi] && (array_reg[gi] == update_upper_PC_in);
    end
  endgenerate

  // A leaf is the victim when every node on its path points toward it,
  // i.e. each node bit equals the leaf's index bit at that level.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_leaf
      for (genvar gj = 0; gj < L; gj++) begin : g_lvl
        localparam int NODE    = (2 ** gj) - 1 + (gi >> (L - gj));
        localparam bit DIR_BIT = ((gi >> (L - 1 - gj)) % 2) == 1;
        assign leaf_agree[gi][gj] = (plru_reg[NODE] == DIR_BIT);
      end
      assign victim_onehot[gi] = &leaf_agree[gi];
    end
  endgenerate

  // Encode hit / victim / first-free indices and pick the update target.
  always_comb begin
    hit_idx    = '0;
    victim_idx = '0;
    free_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // Duplicates never exist and the victim is one-hot, so OR-encoding is exact.
      if (match_vec[i]) hit_idx = hit_idx | LOG_UPCT_ENTRIES'(i);
      if (victim_onehot[i]) victim_idx = victim_idx | LOG_UPCT_ENTRIES'(i);
    end
    // Descending scan leaves the lowest invalid index in free_idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_reg[i]) free_idx = LOG_UPCT_ENTRIES'(i);
    end
    upd_hit    = |match_vec;
    any_free   = ~&valid_reg;
    upd_accept = update_valid_in && !flush_in;
    upd_write  = upd_accept && !upd_hit;
    if (upd_hit)       target_idx = hit_idx;
    else if (any_free) target_idx = free_idx;
    else               target_idx = victim_idx;
  end

  // Per-node touch logic: the read touch applies first, the update touch
  // overrides it on shared nodes, and flush clears the whole tree.
  generate
    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
      localparam int           LVL   = $clog2(gi + 2) - 1;
      localparam int           SHIFT = L - LVL;
      localparam int           BITP  = L - 1 - LVL;
      localparam logic [L-1:0] POS   = LOG_UPCT_ENTRIES'(gi - ((2 ** LVL) - 1));
      logic rd_on;
      logic up_on;
      assign rd_on = read_valid_in && ((read_index_in >> SHIFT) == POS);
      assign up_on = upd_accept && ((target_idx >> SHIFT) == POS);
      // Touching points the node away from the touched index.
      assign plru_after_read[gi] = rd_on ? ~read_index_in[BITP] : plru_reg[gi];
      assign plru_next[gi]       = flush_in ? 1'b0
                                 : (up_on ? ~target_idx[BITP] : plru_after_read[gi]);
    end
  endgenerate

  // Valid bits: flush clears all, an allocating update sets the target.
  always_comb begin
    valid_next = valid_reg;
    if (flush_in) begin
      valid_next = '0;
    end else if (upd_write) begin
      valid_next[target_idx] = 1'b1;
    end
  end

  // Array write on allocation; reads elsewhere see the pre-write value.
  always_ff @(posedge CLK) begin
    if (upd_write) begin
      array_reg[target_idx] <= update_upper_PC_in;
    end
  end

  // Control state and registered outputs, cleared asynchronously by RST.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_reg         <= '0;
      plru_reg          <= '0;
      read_upper_PC_out <= '0;
      update_ack_out    <= 1'b0;
      update_hit_out    <= 1'b0;
      update_index_out  <= '0;
    end else begin
      valid_reg      <= valid_next;
      plru_reg       <= plru_next;
      update_ack_out <= upd_accept;
      if (read_valid_in) begin
        read_upper_PC_out <= array_reg[read_index_in];
      end
      if (upd_accept) begin
        update_hit_out   <= upd_hit;
        update_index_out <= target_idx;
      end
    end
  end

endmodule

// File: tb/tb_upct_plru.sv
// Directed bench for upct_plru with 8 entries; expected values hand-derived.
module tb_upct_plru;

  localparam int N = 8;
  localparam int L = 3;
  localparam int W = 21;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         read_valid_in = 1'b0;
  logic [L-1:0] read_index_in = '0;
  logic [W-1:0] read_upper_PC_out;
  logic         update_valid_in = 1'b0;
  logic [W-1:0] update_upper_PC_in = '0;
  logic         update_ack_out;
  logic         update_hit_out;
  logic [L-1:0] update_index_out;
  logic         flush_in = 1'b0;

  int checks = 0;
  int errors = 0;

  upct_plru #(
    .UPCT_ENTRIES(N),
    .LOG_UPCT_ENTRIES(L),
    .UPPER_PC_WIDTH(W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .read_valid_in(read_valid_in),
    .read_index_in(read_index_in),
    .read_upper_PC_out(read_upper_PC_out),
    .update_valid_in(update_valid_in),
    .update_upper_PC_in(update_upper_PC_in),
    .update_ack_out(update_ack_out),
    .update_hit_out(update_hit_out),
    .update_index_out(update_index_out),
    .flush_in(flush_in)
  );

  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    read_valid_in   = 1'b0;
    update_valid_in = 1'b0;
    flush_in        = 1'b0;
  endtask

  // Flush then insert 0x100..0x107 in order: indices 0..7, touch order 0..7.
  task automatic fill_table();
    idle();
    flush_in = 1'b1;
    step();
    idle();
    for (int i = 0; i < N; i++) begin
      update_valid_in    = 1'b1;
      update_upper_PC_in = W'(32'h100 + i);
      step();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    step();
    step();
    checks++; if (read_upper_PC_out !== '0) begin errors++; $display("FAIL reset_read got %0h want 0", read_upper_PC_out); end
    checks++; if (update_ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack got %0h want 0", update_ack_out); end
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL reset_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== '0) begin errors++; $display("FAIL reset_index got %0h want 0", update_index_out); end
    RST = 1'b0;
    // Allocate into an empty table.
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h12345;
    step();
    idle();
    $display("alloc 0x12345: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_ack_out !== 1'b1) begin errors++; $display("FAIL alloc_ack got %0h want 1", update_ack_out); end
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL alloc_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd0) begin errors++; $display("FAIL alloc_index got %0h want 0", update_index_out); end
    read_valid_in = 1'b1;
    read_index_in = 3'd0;
    step();
    idle();
    $display("read idx0: data=%0h ack=%0d", read_upper_PC_out, update_ack_out);
    checks++; if (read_upper_PC_out !== 21'h12345) begin errors++; $display("FAIL alloc_read got %0h want 12345", read_upper_PC_out); end
    checks++; if (update_ack_out !== 1'b0) begin errors++; $display("FAIL ack_pulse got %0h want 0", update_ack_out); end
  endtask

  task automatic test_fill_hit();
    idle();
    flush_in = 1'b1;
    step();
    idle();
    for (int i = 0; i < N; i++) begin
      update_valid_in    = 1'b1;
      update_upper_PC_in = W'(32'h100 + i);
      step();
      $display("fill %0h: ack=%0d hit=%0d idx=%0d", update_upper_PC_in, update_ack_out, update_hit_out, update_index_out);
      checks++; if (update_ack_out !== 1'b1) begin errors++; $display("FAIL fill_ack[%0d] got %0h want 1", i, update_ack_out); end
      checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL fill_hit[%0d] got %0h want 0", i, update_hit_out); end
      checks++; if (update_index_out !== L'(i)) begin errors++; $display("FAIL fill_index[%0d] got %0h want %0h", i, update_index_out, i); end
    end
    update_upper_PC_in = 21'h103;
    step();
    idle();
    $display("lookup 0x103: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_hit_out !== 1'b1) begin errors++; $display("FAIL hit_103 got %0h want 1", update_hit_out); end
    checks++; if (update_index_out !== 3'd3) begin errors++; $display("FAIL hit_103_index got %0h want 3", update_index_out); end
  endtask

  task automatic test_plru_eviction();
    fill_table();
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h200;
    step();
    $display("evict 0x200: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL evict_200_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd0) begin errors++; $display("FAIL evict_200_index got %0h want 0", update_index_out); end
    update_upper_PC_in = 21'h201;
    step();
    $display("evict 0x201: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_index_out !== 3'd4) begin errors++; $display("FAIL evict_201_index got %0h want 4", update_index_out); end
    update_upper_PC_in = 21'h100;
    step();
    idle();
    $display("evict 0x100: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL evicted_100_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd2) begin errors++; $display("FAIL evicted_100_index got %0h want 2", update_index_out); end
  endtask

  task automatic test_flush_priority();
    flush_in           = 1'b1;
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h300;
    step();
    $display("flush+update 0x300: ack=%0d", update_ack_out);
    checks++; if (update_ack_out !== 1'b0) begin errors++; $display("FAIL flush_drop_ack got %0h want 0", update_ack_out); end
    flush_in = 1'b0;
    step();
    $display("update 0x300: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_ack_out !== 1'b1) begin errors++; $display("FAIL post_flush_ack got %0h want 1", update_ack_out); end
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL post_flush_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd0) begin errors++; $display("FAIL post_flush_index got %0h want 0", update_index_out); end
    update_upper_PC_in = 21'h101;
    step();
    idle();
    $display("update 0x101: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL flushed_101_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd1) begin errors++; $display("FAIL flushed_101_index got %0h want 1", update_index_out); end
  endtask

  task automatic test_same_cycle();
    fill_table();
    read_valid_in      = 1'b1;
    read_index_in      = 3'd0;
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h400;
    step();
    idle();
    $display("read0+update 0x400: data=%0h ack=%0d hit=%0d idx=%0d", read_upper_PC_out, update_ack_out, update_hit_out, update_index_out);
    checks++; if (read_upper_PC_out !== 21'h100) begin errors++; $display("FAIL rbw_read got %0h want 100", read_upper_PC_out); end
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL rbw_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd0) begin errors++; $display("FAIL rbw_index got %0h want 0", update_index_out); end
    read_valid_in = 1'b1;
    read_index_in = 3'd0;
    step();
    idle();
    $display("read idx0: data=%0h", read_upper_PC_out);
    checks++; if (read_upper_PC_out !== 21'h400) begin errors++; $display("FAIL rbw_reread got %0h want 400", read_upper_PC_out); end
    // A read alongside flush still returns data.
    read_valid_in = 1'b1;
    read_index_in = 3'd1;
    flush_in      = 1'b1;
    step();
    idle();
    $display("flush+read idx1: data=%0h ack=%0d", read_upper_PC_out, update_ack_out);
    checks++; if (read_upper_PC_out !== 21'h101) begin errors++; $display("FAIL flush_read got %0h want 101", read_upper_PC_out); end
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h400;
    step();
    idle();
    $display("update 0x400 after flush: hit=%0d idx=%0d", update_hit_out, update_index_out);
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL flush_inval_hit got %0h want 0", update_hit_out); end
  endtask

  task automatic test_back_to_back();
    idle();
    flush_in = 1'b1;
    step();
    idle();
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h55;
    step();
    $display("b2b 0x55 #1: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL b2b_first_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd0) begin errors++; $display("FAIL b2b_first_index got %0h want 0", update_index_out); end
    step();
    idle();
    $display("b2b 0x55 #2: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_ack_out !== 1'b1) begin errors++; $display("FAIL b2b_second_ack got %0h want 1", update_ack_out); end
    checks++; if (update_hit_out !== 1'b1) begin errors++; $display("FAIL b2b_second_hit got %0h want 1", update_hit_out); end
    checks++; if (update_index_out !== 3'd0) begin errors++; $display("FAIL b2b_second_index got %0h want 0", update_index_out); end
    step();
    $display("idle: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_ack_out !== 1'b0) begin errors++; $display("FAIL idle_ack got %0h want 0", update_ack_out); end
    checks++; if (update_hit_out !== 1'b1) begin errors++; $display("FAIL idle_hit_hold got %0h want 1", update_hit_out); end
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h66;
    step();
    idle();
    $display("update 0x66: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_index_out !== 3'd1) begin errors++; $display("FAIL b2b_66_index got %0h want 1", update_index_out); end
    // Reset between edges must clear outputs without waiting for a clock.
    #2;
    RST = 1'b1;
    #1;
    $display("async reset: data=%0h ack=%0d hit=%0d idx=%0d", read_upper_PC_out, update_ack_out, update_hit_out, update_index_out);
    checks++; if (read_upper_PC_out !== '0) begin errors++; $display("FAIL arst_read got %0h want 0", read_upper_PC_out); end
    checks++; if (update_ack_out !== 1'b0) begin errors++; $display("FAIL arst_ack got %0h want 0", update_ack_out); end
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL arst_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== '0) begin errors++; $display("FAIL arst_index got %0h want 0", update_index_out); end
    step();
    RST = 1'b0;
    update_valid_in    = 1'b1;
    update_upper_PC_in = 21'h66;
    step();
    idle();
    $display("update 0x66 after reset: ack=%0d hit=%0d idx=%0d", update_ack_out, update_hit_out, update_index_out);
    checks++; if (update_hit_out !== 1'b0) begin errors++; $display("FAIL arst_valid_hit got %0h want 0", update_hit_out); end
    checks++; if (update_index_out !== 3'd0) begin errors++; $display("FAIL arst_valid_index got %0h want 0", update_index_out); end
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_plru_eviction();
    test_flush_priority();
    test_same_cycle();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upct_plru.md
# upct_plru

Parametrised upper-PC table (UPCT) for the fetch predictors. It stores up to UPCT_ENTRIES distinct upper target-PC fields so that BTB entries carry only a short index. This generation generalises entry count to any power of two, using tree-PLRU replacement with invalid-first allocation. It also adds a flush, a PLRU-touching read port, and defined same-cycle read/update priority. It sits beside the BTB in the fetch predictor cluster.

## Interface
- UPCT_ENTRIES, 8, entry count; power of two, 2 to 64
- LOG_UPCT_ENTRIES, $clog2(UPCT_ENTRIES), index width
- UPPER_PC_WIDTH, 21, stored field width (32 - BTB_TARGET_WIDTH - 1)
- CLK  input  1  clock, all state on rising edge
- RST  input  1  reset, asynchronous, active-high
- read_valid_in  input  1  read request
- read_index_in  input  LOG_UPCT_ENTRIES  entry to read
- read_upper_PC_out  output  UPPER_PC_WIDTH  registered read data
- update_valid_in  input  1  lookup/allocate request
- update_upper_PC_in  input  UPPER_PC_WIDTH  value to find or insert
- update_ack_out  output  1  registered pulse: update result valid
- update_hit_out  output  1  registered: value was already present
- update_index_out  output  LOG_UPCT_ENTRIES  registered: entry holding value
- flush_in  input  1  invalidate all entries, reset PLRU

## Operation
- State:
  - array[UPCT_ENTRIES] of UPPER_PC_WIDTH
  - valid[UPCT_ENTRIES]
  - plru[UPCT_ENTRIES-1], heap-ordered: node n has children 2n+1 and 2n+2
- Tree-PLRU node convention:
  - bit 0: victim lies in the lower-index half.
  - Touching index i sets each node on i's path to point away from i: bit 1 if i is in the lower half, else 0.
- Read: when read_valid_in is high, array[read_index_in] is registered to read_upper_PC_out and read_index_in is touched. Valid bits are ignored. When read_valid_in is low, the output holds its value.
- Update: update_upper_PC_in is compared combinationally against all valid entries.
  - Hit: register hit=1 and the matching index (duplicates cannot occur), then touch that index.
  - Miss: the target is the lowest-index invalid entry if any exists, else the PLRU victim. Write the value, set valid, touch the target, register hit=0 and the target index.
- Simultaneous read and update in one cycle:
  - Apply the read touch first, then the update touch; the update wins on shared nodes.
  - A read returns the pre-write array value (read-before-write), including when the update writes the same index.
- Flush:
  - Clears all valid bits and all plru bits at the edge.
  - A same-cycle update is dropped: no write, no ack.
  - A same-cycle read still completes, but does not touch the PLRU (it is cleared).
- Outputs do not depend combinationally on inputs.

## Timing
- Read latency: 1 cycle. A request at edge t gives data after edge t.
- Update latency: 1 cycle. update_ack_out is high for exactly one cycle after each accepted update. hit and index are valid only while ack is high and hold otherwise.
- Back-to-back updates are accepted every cycle. An update at t+1 sees the state written at t, so a repeat of the same value hits.
- There is no backpressure and no stall input.
- RST asserted, including mid-operation:
  - Immediately clears valid, plru, read_upper_PC_out, update_ack_out, update_hit_out and update_index_out to 0.
  - Array contents are don't-care.
  - In-flight results are lost.
  - First accepted request: the edge after RST deasserts.

## Test plan
All cases use UPCT_ENTRIES=8.
- Reset and allocate:
  - During RST, all outputs are 0.
  - Update 0x12345 -> next cycle ack=1, hit=0, index=0.
  - Then read index 0 -> next cycle read_upper_PC_out=0x12345.
- Fill and hit:
  - Updates 0x100..0x107 on consecutive cycles -> indices 0..7, hit=0 each.
  - Then update 0x103 -> hit=1, index=3.
- PLRU eviction:
  - After the fill (touch order 0..7), update 0x200 -> hit=0, index=0.
  - Then update 0x201 -> index=4.
  - Then update 0x100 -> miss (evicted).
- Flush priority:
  - With the table full, flush_in and update 0x300 in the same cycle -> no ack the next cycle.
  - Then update 0x300 -> index=0, hit=0.
  - Then update 0x101 -> hit=0, index=1.
- Same-cycle read/write:
  - Table full with 0x100..0x107, victim 0; read index 0 with update 0x400 -> read returns 0x100, update index=0.
  - Next read of index 0 -> 0x400.
- Back-to-back duplicate and async reset:
  - Update 0x55 at t and t+1 -> hit=0 then hit=1, same index.
  - Assert RST mid-sequence between clock edges -> outputs drop to 0 immediately.
